// File: rtl/text_pkg.sv
// Shared ASCII constants and helpers for the text-processing case converters.
package text_pkg;

    localparam logic [7:0] ASCII_UPPER_A     = 8'd65;
    localparam logic [7:0] ASCII_UPPER_Z     = 8'd90;
    localparam logic [7:0] ASCII_LOWER_A     = 8'd97;
    localparam logic [7:0] ASCII_LOWER_Z     = 8'd122;
    localparam logic [7:0] ASCII_CASE_OFFSET = 8'd32;

    function automatic logic is_upper(input logic [7:0] ch);
        return (ch >= ASCII_UPPER_A) && (ch <= ASCII_UPPER_Z);
    endfunction

    function automatic logic is_lower(input logic [7:0] ch);
        return (ch >= ASCII_LOWER_A) && (ch <= ASCII_LOWER_Z);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; the head entry is presented directly
// from storage, so there is no combinational path from write data to read data.
module sync_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              wr_ok;
    logic              rd_ok;

    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    // NOTE: storage is deliberately not reset; stale entries are unreachable once
    // the pointers and count are cleared, and rd_data is masked while empty.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + (ADDR_W + 1)'(1);
                2'b01:   count <= count - (ADDR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/to_lower_stream.sv
// Streaming ASCII upper-to-lower converter: converts on the write side of a small
// FIFO and keeps saturating counts of accepted and converted bytes.
module to_lower_stream
    import text_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] char_cnt,
    output logic [CNT_W-1:0] conv_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic       push;
    logic       pop;
    logic       full;
    logic       empty;
    logic [7:0] wr_data;

    function automatic logic [7:0] to_lower(input logic [7:0] ch);
        return is_upper(ch) ? ch + ASCII_CASE_OFFSET : ch;
    endfunction

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign wr_data   = to_lower(in_data);

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (out_data),
        .full    (full),
        .empty   (empty)
    );

    // Clearing wins over a same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            char_cnt <= '0;
            conv_cnt <= '0;
        end else if (push) begin
            if (char_cnt != CNT_MAX) begin
                char_cnt <= char_cnt + CNT_W'(1);
            end
            if (is_upper(in_data) && (conv_cnt != CNT_MAX)) begin
                conv_cnt <= conv_cnt + CNT_W'(1);
            end
        end
    end

endmodule
